// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_arbiter
// Purpose  : Round-robin arbiter and access sequencer that gives two
//            requesters shared use of one register-file read/write path.
// Revision : 1.0
// ============================================================================
module regfile_port_arbiter #(
   parameter int READ_LAT      = 2,
   parameter int FLAG_ADDR     = 3,
   parameter int PROTECT_FLAGS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic       req0_we,
   input  logic [7:0] req0_addr,
   input  logic [7:0] req0_wdata,
   output logic       rsp0_valid,
   output logic       rsp0_err,
   output logic [7:0] rsp0_rdata,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic       req1_we,
   input  logic [7:0] req1_addr,
   input  logic [7:0] req1_wdata,
   output logic       rsp1_valid,
   output logic       rsp1_err,
   output logic [7:0] rsp1_rdata,
   output logic [7:0] rf_a1,
   output logic [7:0] rf_a3,
   output logic [7:0] rf_wdata,
   output logic       rf_we,
   output logic       rf_re,
   input  logic [7:0] rf_rd1,
   output logic       busy
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_rd   = 2'd1;
   localparam logic [1:0] c_wr   = 2'd2;
   localparam logic [1:0] c_resp = 2'd3;

   localparam int             CNT_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(READ_LAT - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic             r_last_grant;
   logic             r_port;
   logic             r_we;
   logic             r_err;
   logic [7:0]       r_addr;
   logic [7:0]       r_wdata;
   logic [7:0]       r_rdata;
   logic [CNT_W-1:0] r_cnt;

   logic             w_accept;
   logic             w_sel;
   logic             w_sel_we;
   logic [7:0]       w_sel_addr;
   logic             w_reject;
   logic             w_rd_done;

   // Under contention the port that did not win last time gets the grant.
   assign w_accept   = (r_state == c_idle) && (req0_valid || req1_valid);
   assign w_sel      = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
   assign w_sel_we   = w_sel ? req1_we   : req0_we;
   assign w_sel_addr = w_sel ? req1_addr : req0_addr;
   assign w_reject   = (w_sel_addr[7:5] != 3'd0) ||
                       (w_sel_we && (PROTECT_FLAGS != 0) && (w_sel_addr == 8'(FLAG_ADDR)));
   assign w_rd_done  = (r_state == c_rd) && (r_cnt == c_cnt_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle: begin
            if (w_accept) begin
               if (w_reject)      w_next = c_resp;
               else if (w_sel_we) w_next = c_wr;
               else               w_next = c_rd;
            end
         end
         c_rd:    if (w_rd_done) w_next = c_resp;
         c_wr:    w_next = c_resp;
         c_resp:  w_next = c_idle;
         default: w_next = c_idle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_port       <= 1'b0;
         r_we         <= 1'b0;
         r_err        <= 1'b0;
         r_addr       <= 8'd0;
         r_wdata      <= 8'd0;
         r_rdata      <= 8'd0;
         r_cnt        <= '0;
      end else if (w_accept) begin
         r_last_grant <= w_sel;
         r_port       <= w_sel;
         r_we         <= w_sel_we;
         r_err        <= w_reject;
         r_addr       <= w_sel_addr;
         r_wdata      <= w_sel ? req1_wdata : req0_wdata;
         r_rdata      <= 8'd0;
         r_cnt        <= '0;
      end else if (r_state == c_rd) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_rd_done) r_rdata <= rf_rd1;
      end
   end

   // Ready is masked by rst_n so every output is quiet while reset is held.
   always_comb begin
      req0_ready = rst_n && w_accept && !w_sel;
      req1_ready = rst_n && w_accept &&  w_sel;
      rf_re      = (r_state == c_rd);
      rf_a1      = (r_state == c_rd) ? r_addr : 8'd0;
      rf_we      = (r_state == c_wr) && r_we;
      rf_a3      = (r_state == c_wr) ? r_addr : 8'd0;
      rf_wdata   = (r_state == c_wr) ? r_wdata : 8'd0;
      rsp0_valid = (r_state == c_resp) && !r_port;
      rsp1_valid = (r_state == c_resp) &&  r_port;
      rsp0_err   = rsp0_valid && r_err;
      rsp1_err   = rsp1_valid && r_err;
      rsp0_rdata = rsp0_valid ? r_rdata : 8'd0;
      rsp1_rdata = rsp1_valid ? r_rdata : 8'd0;
      busy       = (r_state != c_idle);
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_port_arbiter
// Purpose  : Directed self-checking bench for regfile_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_regfile_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req0_we = 1'b0;
   logic [7:0] req0_addr = 8'd0, req0_wdata = 8'd0;
   logic       req1_valid = 1'b0, req1_we = 1'b0;
   logic [7:0] req1_addr = 8'd0, req1_wdata = 8'd0;
   logic       req0_ready, rsp0_valid, rsp0_err;
   logic       req1_ready, rsp1_valid, rsp1_err;
   logic [7:0] rsp0_rdata, rsp1_rdata;
   logic [7:0] rf_a1, rf_a3, rf_wdata, rf_rd1;
   logic       rf_we, rf_re, busy;

   logic [7:0] mem [32];
   int         n_checks = 0;
   int         n_pass   = 0;

   always #5 clk = ~clk;

   regfile_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err), .rsp1_rdata(rsp1_rdata),
      .rf_a1(rf_a1), .rf_a3(rf_a3), .rf_wdata(rf_wdata),
      .rf_we(rf_we), .rf_re(rf_re), .rf_rd1(rf_rd1), .busy(busy)
   );

   // Register file stand-in: combinational read, write on the clock edge.
   assign rf_rd1 = rf_re ? mem[rf_a1[4:0]] : 8'h00;
   always @(posedge clk) if (rf_we) mem[rf_a3[4:0]] <= rf_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int grants[4];
   int n_grants;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      mem[1] = 8'h11;
      mem[2] = 8'h22;
      mem[3] = 8'h5C;

      // Reset: outputs quiet even with a request pending
      req0_valid = 1'b1;
      tick(); tick();
      chk("rst_ready0", req0_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rfwe", rf_we, 0);
      req0_valid = 1'b0;
      rst_n = 1'b1;
      tick();

      // req0 write addr 5 = 0xA7
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'd5; req0_wdata = 8'hA7;
      #1;
      chk("wr_ready0", req0_ready, 1);
      chk("wr_ready1", req1_ready, 0);
      tick();
      req0_valid = 1'b0;
      chk("wr_rfwe", rf_we, 1);
      chk("wr_a3", rf_a3, 8'd5);
      chk("wr_wdata", rf_wdata, 8'hA7);
      chk("wr_rfre", rf_re, 0);
      tick();
      chk("wr_rsp_valid", rsp0_valid, 1);
      chk("wr_rsp_err", rsp0_err, 0);
      chk("wr_rsp_rdata", rsp0_rdata, 0);
      chk("wr_rfwe_off", rf_we, 0);
      tick();
      chk("wr_idle", busy, 0);

      // req1 read addr 5
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'd5;
      #1;
      chk("rd_ready1", req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      chk("rd_re_t1", rf_re, 1);
      chk("rd_a1_t1", rf_a1, 8'd5);
      chk("rd_rsp_t1", rsp1_valid, 0);
      tick();
      chk("rd_re_t2", rf_re, 1);
      chk("rd_a1_t2", rf_a1, 8'd5);
      chk("rd_rsp_t2", rsp1_valid, 0);
      tick();
      chk("rd_rsp_valid", rsp1_valid, 1);
      chk("rd_rsp_rdata", rsp1_rdata, 8'hA7);
      chk("rd_rsp_err", rsp1_err, 0);
      chk("rd_re_off", rf_re, 0);
      chk("rd_a1_off", rf_a1, 0);
      tick();

      // Contention: both valid continuously, expect 0,1,0,1
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'd1;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'd2;
      n_grants = 0;
      for (int c = 0; c < 40 && n_grants < 4; c++) begin
         #1;
         chk("rr_not_both", req0_ready && req1_ready, 0);
         if (req0_ready || req1_ready) begin
            grants[n_grants] = req1_ready ? 1 : 0;
            n_grants++;
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("rr_grant_count", n_grants, 4);
      chk("rr_g0", grants[0], 0);
      chk("rr_g1", grants[1], 1);
      chk("rr_g2", grants[2], 0);
      chk("rr_g3", grants[3], 1);
      for (int c = 0; c < 10 && busy; c++) tick();
      chk("rr_drain", busy, 0);

      // Protected flag register write rejected
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'd3; req0_wdata = 8'hFF;
      #1;
      chk("flag_ready0", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      chk("flag_rsp_valid", rsp0_valid, 1);
      chk("flag_rsp_err", rsp0_err, 1);
      chk("flag_rfwe", rf_we, 0);
      tick();

      // Reading the flag register is allowed and returns the untouched value
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'd3;
      tick();
      req0_valid = 1'b0;
      tick(); tick();
      chk("flag_rd_valid", rsp0_valid, 1);
      chk("flag_rd_err", rsp0_err, 0);
      chk("flag_rd_rdata", rsp0_rdata, 8'h5C);
      tick();

      // Out-of-range read rejected
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h25;
      tick();
      req1_valid = 1'b0;
      chk("oor_valid", rsp1_valid, 1);
      chk("oor_err", rsp1_err, 1);
      chk("oor_rdata", rsp1_rdata, 0);
      chk("oor_rfre", rf_re, 0);
      tick();

      // Reset during RD discards the read
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'd1;
      tick();
      req0_valid = 1'b0;
      chk("rrst_in_rd", rf_re, 1);
      rst_n = 1'b0;
      #1;
      chk("rrst_re", rf_re, 0);
      chk("rrst_a1", rf_a1, 0);
      chk("rrst_busy", busy, 0);
      tick();
      chk("rrst_rsp", rsp0_valid, 0);
      rst_n = 1'b1;
      tick();
      chk("rrst_rsp_after", rsp0_valid, 0);

      // First contention after reset goes to port 0
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rrst_win0", req0_ready, 1);
      chk("rrst_lose1", req1_ready, 0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int c = 0; c < 10 && busy; c++) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
